uart_tx_csr_bank: RTL
=====================

// Module: uart_tx_csr_bank
// PURPOSE
//  Parametrised memory-mapped control/status register bank for the UART transmitter.
//  - Holds line configuration, the baud divisor and a one-deep TX data holding register.
//  - Offers a valid/ready handshake to the TX datapath.
//  - Tracks sticky done/overrun status.
//  - Sits between the core's load/store bus and the UART Tx shift engine.
// PARAMETERS
//  DATA_W    8       TX character width (5..9)
//  BAUD_W    16      baud divisor register width
//  BAUD_RST  434     baud divisor reset value
//  BUS_W     32      bus data width (>= DATA_W, >= BAUD_W, >= 6)
//  ADDR_W    2       word-index address width (4 registers)
// PORTS
//  clk          in   1       clock
//  reset        in   1       synchronous, active-high reset
//  wr_en        in   1       bus write strobe
//  rd_en        in   1       bus read strobe
//  addr         in   ADDR_W  register word index
//  wdata        in   BUS_W   write data
//  rdata        out  BUS_W   read data, registered
//  tx_en        out  1       CTRL[0]
//  two_stop     out  1       CTRL[1]
//  odd_parity   out  1       CTRL[2]
//  parity_en    out  1       CTRL[3]
//  baud_div     out  BAUD_W  BAUD register
//  tx_data      out  DATA_W  holding register contents
//  tx_valid     out  1       holding register full
//  tx_ready     in   1       Tx engine accepts tx_data when tx_valid & tx_ready
//  tx_busy      in   1       Tx engine shifting (status only)
//  tx_done      in   1       1-cycle pulse at end of stop bit(s)
//  irq          out  1       only when UART_TX_CSR_IRQ_EN is defined
// BEHAVIOUR
//  Register map (word index):
//   0 CTRL RW
//   1 STATUS {overrun[3] W1C, done[2] W1C, busy[1] RO, full[0] RO}
//   2 TXDATA W; read returns last written data
//   3 BAUD RW
//  Reset values:
//   - All outputs and registers 0, except baud_div = BAUD_RST.
//   - rdata = 0, irq = 0.
//  Reads:
//   - rdata is updated on the clock edge after rd_en (1-cycle latency) and holds until the next rd_en.
//   - Unused bits read 0.
//   - A simultaneous write to the same register returns the pre-write value.
//  CTRL writes:
//   - bit0 (tx_en) is always writable.
//   - bits[3:1] and BAUD are writable only while the current tx_en = 0; otherwise they are silently ignored.
//   - A write that clears tx_en does not update bits[3:1] in that same cycle.
//  TXDATA writes:
//   - If full = 0: latch wdata[DATA_W-1:0] and set full on the next edge.
//   - If full = 1 and no handshake occurs this cycle: drop the data and set overrun.
//   - If full = 1 and a handshake occurs the same cycle: accept the new data, full stays 1, no overrun.
//  Handshake:
//   - tx_valid = full.
//   - tx_valid & tx_ready clears full on the next edge unless a write is accepted in that cycle.
//   - tx_data is stable while tx_valid = 1.
//  Sticky bits:
//   - done is set by the tx_done pulse; overrun is set per the TXDATA rules.
//   - Writing 1 to the bit position clears it; writing 0 has no effect.
//   - A set and a clear in the same cycle: set wins.
//  Out-of-range addresses: no effect on write, read returns 0.
//  Reset mid-operation:
//   - Clears full/done/overrun and returns to the reset state on the next edge.
//   - A pending character is discarded.
// CONFIGURATION
//  Macro UART_TX_CSR_IRQ_EN:
//   - Defined:
//     - CTRL[4] = done_ie, CTRL[5] = empty_ie (always writable).
//     - irq = (done & done_ie) | (~full & tx_en & empty_ie) | overrun, registered (1-cycle delay).
//   - Undefined:
//     - CTRL[5:4] read 0 and ignore writes.
//     - The irq port does not exist.
// STRUCTURE
//  Package uart_pkg:
//   - Register index localparams CTRL_IDX, STATUS_IDX, TXDATA_IDX, BAUD_IDX.
//   - CTRL/STATUS bit-position localparams.
//   - typedef struct packed ctrl_t {empty_ie, done_ie, parity_en, odd_parity, two_stop, tx_en}.
//  Sub-module uart_w1c_bit: one sticky bit with set/clear inputs (set priority); instantiated for done and overrun.
// TESTING
//  1. Reset, read addr 3 -> rdata = 434 one cycle later; read 0 -> 0; tx_valid = 0.
//  2. CTRL = 0x0E, then CTRL = 0x0F, then CTRL = 0x01 -> after each write, CTRL reads 0x0E, 0x0F, 0x0F (locked while tx_en = 1).
//  3. With tx_ready = 0, write TXDATA 0x41 then 0x42:
//     - tx_data = 0x41, tx_valid = 1, STATUS reads 0x9 (overrun + full).
//     - Write STATUS 0x8 -> STATUS reads 0x1.
//  4. While full = 1, write TXDATA 0x55 in the same cycle as tx_ready = 1:
//     - tx_valid stays 1, tx_data = 0x55, overrun = 0.
//     - Next tx_ready pulse -> tx_valid = 0.
//  5. tx_done pulse in the same cycle as a STATUS 0x4 write -> done reads 1; a later 0x4 write -> done reads 0.
//  6. With UART_TX_CSR_IRQ_EN defined:
//     - CTRL = 0x11, tx_done pulse -> irq = 1 two edges later.
//     - W1C done -> irq = 0.
//     - Reset asserted with full = 1 -> tx_valid = 0 next edge.

Source files
------------

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// uart_pkg : register map, bit positions and CTRL layout of the UART TX CSRs
// Revision : 1.0
// ============================================================================
package uart_pkg;

    localparam int CTRL_IDX   = 0;
    localparam int STATUS_IDX = 1;
    localparam int TXDATA_IDX = 2;
    localparam int BAUD_IDX   = 3;

    localparam int CTRL_TX_EN    = 0;
    localparam int CTRL_TWO_STOP = 1;
    localparam int CTRL_ODD_PAR  = 2;
    localparam int CTRL_PAR_EN   = 3;
    localparam int CTRL_DONE_IE  = 4;
    localparam int CTRL_EMPTY_IE = 5;
    localparam int CTRL_W        = 6;

    localparam int STATUS_FULL    = 0;
    localparam int STATUS_BUSY    = 1;
    localparam int STATUS_DONE    = 2;
    localparam int STATUS_OVERRUN = 3;

    typedef struct packed {
        logic empty_ie;
        logic done_ie;
        logic parity_en;
        logic odd_parity;
        logic two_stop;
        logic tx_en;
    } ctrl_t;

endpackage
`default_nettype wire

// File: rtl/uart_w1c_bit.sv
`default_nettype none
// ============================================================================
// uart_w1c_bit : single sticky status bit, set has priority over clear
// Revision     : 1.0
// ============================================================================
module uart_w1c_bit (
    input  logic clk,
    input  logic reset,
    input  logic set,
    input  logic clr,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else if (set) begin
            q <= 1'b1;
        end else if (clr) begin
            q <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_csr_bank.sv
`default_nettype none
// ============================================================================
// uart_tx_csr_bank : UART TX control/status register bank with TX holding reg
// Optional interrupt output when UART_TX_CSR_IRQ_EN is defined.  Revision 1.0
// ============================================================================
module uart_tx_csr_bank
    import uart_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int BAUD_W   = 16,
    parameter int BAUD_RST = 434,
    parameter int BUS_W    = 32,
    parameter int ADDR_W   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [BUS_W-1:0]  wdata,
    output logic [BUS_W-1:0]  rdata,
    output logic              tx_en,
    output logic              two_stop,
    output logic              odd_parity,
    output logic              parity_en,
    output logic [BAUD_W-1:0] baud_div,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic              tx_busy,
    input  logic              tx_done
`ifdef UART_TX_CSR_IRQ_EN
    ,
    output logic              irq
`endif
);

    ctrl_t             ctrl;
    logic              full;
    logic              done;
    logic              overrun;
    logic [DATA_W-1:0] hold;
    logic [DATA_W-1:0] last_wr;
    logic              wr_ctrl;
    logic              wr_status;
    logic              wr_txdata;
    logic              wr_baud;
    logic              handshake;
    logic              wr_accept;
    logic              ovr_set;
    logic [BUS_W-1:0]  rd_word;
    logic              unused_wdata;

    assign wr_ctrl   = wr_en && (addr == ADDR_W'(CTRL_IDX));
    assign wr_status = wr_en && (addr == ADDR_W'(STATUS_IDX));
    assign wr_txdata = wr_en && (addr == ADDR_W'(TXDATA_IDX));
    assign wr_baud   = wr_en && (addr == ADDR_W'(BAUD_IDX));

    assign unused_wdata = ^wdata;

    // Line configuration and divisor are frozen while the transmitter is enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            baud_div <= BAUD_W'(BAUD_RST);
        end else begin
            if (wr_ctrl) begin
                ctrl.tx_en <= wdata[CTRL_TX_EN];
                if (!ctrl.tx_en) begin
                    ctrl.two_stop   <= wdata[CTRL_TWO_STOP];
                    ctrl.odd_parity <= wdata[CTRL_ODD_PAR];
                    ctrl.parity_en  <= wdata[CTRL_PAR_EN];
                end
`ifdef UART_TX_CSR_IRQ_EN
                ctrl.done_ie  <= wdata[CTRL_DONE_IE];
                ctrl.empty_ie <= wdata[CTRL_EMPTY_IE];
`endif
            end
            if (wr_baud && !ctrl.tx_en) begin
                baud_div <= wdata[BAUD_W-1:0];
            end
        end
    end

    assign tx_en      = ctrl.tx_en;
    assign two_stop   = ctrl.two_stop;
    assign odd_parity = ctrl.odd_parity;
    assign parity_en  = ctrl.parity_en;

    // A write landing in the same cycle as a handshake refills the slot being drained.
    assign handshake = full & tx_ready;
    assign wr_accept = wr_txdata & (~full | handshake);
    assign ovr_set   = wr_txdata & full & ~tx_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            full    <= 1'b0;
            hold    <= '0;
            last_wr <= '0;
        end else begin
            if (wr_txdata) begin
                last_wr <= wdata[DATA_W-1:0];
            end
            if (wr_accept) begin
                hold <= wdata[DATA_W-1:0];
                full <= 1'b1;
            end else if (handshake) begin
                full <= 1'b0;
            end
        end
    end

    assign tx_data  = hold;
    assign tx_valid = full;

    uart_w1c_bit u_done (
        .clk   (clk),
        .reset (reset),
        .set   (tx_done),
        .clr   (wr_status & wdata[STATUS_DONE]),
        .q     (done)
    );

    uart_w1c_bit u_overrun (
        .clk   (clk),
        .reset (reset),
        .set   (ovr_set),
        .clr   (wr_status & wdata[STATUS_OVERRUN]),
        .q     (overrun)
    );

    always_comb begin
        rd_word = '0;
        case (addr)
            ADDR_W'(CTRL_IDX):   rd_word[CTRL_W-1:0] = ctrl;
            ADDR_W'(STATUS_IDX): begin
                rd_word[STATUS_FULL]    = full;
                rd_word[STATUS_BUSY]    = tx_busy;
                rd_word[STATUS_DONE]    = done;
                rd_word[STATUS_OVERRUN] = overrun;
            end
            ADDR_W'(TXDATA_IDX): rd_word[DATA_W-1:0] = last_wr;
            ADDR_W'(BAUD_IDX):   rd_word[BAUD_W-1:0] = baud_div;
            default:             rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rdata <= '0;
        end else if (rd_en) begin
            rdata <= rd_word;
        end
    end

`ifdef UART_TX_CSR_IRQ_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            irq <= 1'b0;
        end else begin
            irq <= (done & ctrl.done_ie) | (~full & ctrl.tx_en & ctrl.empty_ie) | overrun;
        end
    end
`endif

endmodule
`default_nettype wire
